// File: rtl/state_history_logger.sv
// Circular log of previous states, with registered readback and sticky overflow.
// Define STATE_LOG_DWELL_EN to record how long each state was held.
module state_history_logger #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 16
) (
   input  logic                       iClk,
   input  logic                       iRst_n,
   input  logic                       iClear,
   input  logic [WIDTH-1:0]           iDbgSt,
   input  logic                       iFreeze,
   input  logic [$clog2(DEPTH)-1:0]   iRdIdx,
   output logic [WIDTH-1:0]           oCurrentState,
   output logic [WIDTH-1:0]           oRdState,
   output logic [TS_WIDTH-1:0]        oRdDwell,
   output logic [$clog2(DEPTH):0]     oCount,
   output logic                       oOverflow,
   output logic                       oChange
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

   logic                        clr, xfer, rd_hit;
   logic [IW-1:0]               rd_ptr;
   logic [WIDTH-1:0]            cur_q, cur_d;
   logic [DEPTH-1:0][WIDTH-1:0] hist_q;
   logic [IW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [IW:0]                 cnt_q, cnt_d;
   logic                        ovf_q, ovf_d;
   logic                        chg_q, chg_d;
   logic [WIDTH-1:0]            rd_state_q;

   assign clr    = !iRst_n || iClear;
   assign xfer   = !iFreeze && (iDbgSt != cur_q);
   // Index 0 is the entry written most recently.
   assign rd_ptr = wr_ptr_q - IW'(1) - iRdIdx;
   assign rd_hit = {1'b0, iRdIdx} < cnt_q;

   always_comb begin
      cur_d    = cur_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      chg_d    = 1'b0;
      if (clr) begin
         cur_d    = iDbgSt;
         wr_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else if (xfer) begin
         cur_d    = iDbgSt;
         wr_ptr_d = wr_ptr_q + IW'(1);
         chg_d    = 1'b1;
         if (cnt_q == FULL) ovf_d = 1'b1;
         else               cnt_d = cnt_q + (IW+1)'(1);
      end
   end

   always_ff @(posedge iClk) begin
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      chg_q    <= chg_d;
      if (clr) begin
         hist_q     <= '0;
         rd_state_q <= '0;
      end else begin
         if (xfer) hist_q[wr_ptr_q] <= cur_q;
         rd_state_q <= rd_hit ? hist_q[rd_ptr] : '0;
      end
   end

`ifdef STATE_LOG_DWELL_EN
   logic [TS_WIDTH-1:0]            dwell_q, dwell_d;
   logic [DEPTH-1:0][TS_WIDTH-1:0] hdwell_q;
   logic [TS_WIDTH-1:0]            rd_dwell_q;

   always_comb begin
      dwell_d = dwell_q;
      if (clr || xfer)                    dwell_d = '0;
      else if (!iFreeze && dwell_q != '1) dwell_d = dwell_q + TS_WIDTH'(1);
   end

   always_ff @(posedge iClk) begin
      dwell_q <= dwell_d;
      if (clr) begin
         hdwell_q   <= '0;
         rd_dwell_q <= '0;
      end else begin
         if (xfer) hdwell_q[wr_ptr_q] <= dwell_q;
         rd_dwell_q <= rd_hit ? hdwell_q[rd_ptr] : '0;
      end
   end

   assign oRdDwell = rd_dwell_q;
`else
   assign oRdDwell = '0;
`endif

   assign oCurrentState = cur_q;
   assign oRdState      = rd_state_q;
   assign oCount        = cnt_q;
   assign oOverflow     = ovf_q;
   assign oChange       = chg_q;
endmodule
